// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;
  localparam int unsigned UART_DROP_W = 8;

  typedef enum logic [0:0] {
    TXQ_IDLE      = 1'b0,
    TXQ_WAIT_DONE = 1'b1
  } txq_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular-buffer byte FIFO with occupancy count and registered full/empty flags.
// Writes while full are dropped regardless of a same-cycle read.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [UART_BYTE_W-1:0] rd_data,
  output logic [AW:0]            count,
  output logic                   full,
  output logic                   empty
);

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   do_wr;
  logic                   do_rd;
  logic [AW:0]            count_nxt;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of a UART transmitter: launches one byte per frame, waits for i_tx_done.
// Optional UART_TXQ_DROP_CNT_EN adds o_drop_cnt, a saturating count of writes lost to a full queue.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_wr_dv,
  input  logic [UART_BYTE_W-1:0] i_wr_byte,
  input  logic                   i_tx_done,
  output logic                   o_tx_dv,
  output logic [UART_BYTE_W-1:0] o_tx_byte,
  output logic [AW:0]            o_count,
  output logic                   o_full,
  output logic                   o_empty,
`ifdef UART_TXQ_DROP_CNT_EN
  output logic [UART_DROP_W-1:0] o_drop_cnt,
`endif
  output logic                   o_busy
);

  txq_state_t             state;
  logic                   pop;
  logic [UART_BYTE_W-1:0] head;

  assign pop    = (state == TXQ_IDLE) && !o_empty;
  assign o_busy = (state == TXQ_WAIT_DONE);

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (i_rst),
    .wr_en   (i_wr_dv),
    .wr_data (i_wr_byte),
    .rd_en   (pop),
    .rd_data (head),
    .count   (o_count),
    .full    (o_full),
    .empty   (o_empty)
  );

  // Launch FSM; reset does not touch the downstream frame, it only forgets it.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= TXQ_IDLE;
      o_tx_dv   <= 1'b0;
      o_tx_byte <= '0;
    end else begin
      o_tx_dv <= 1'b0;
      case (state)
        TXQ_IDLE: begin
          if (!o_empty) begin
            o_tx_dv   <= 1'b1;
            o_tx_byte <= head;
            state     <= TXQ_WAIT_DONE;
          end
        end
        TXQ_WAIT_DONE: begin
          if (i_tx_done) begin
            state <= TXQ_IDLE;
          end
        end
      endcase
    end
  end

`ifdef UART_TXQ_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_drop_cnt <= '0;
    end else if (i_wr_dv && o_full && (o_drop_cnt != '1)) begin
      o_drop_cnt <= o_drop_cnt + UART_DROP_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: fixed vector table, directed corner sequences, and
// randomized traffic against a queue-based reference model.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_wr_dv = 1'b0;
  logic [7:0]    i_wr_byte = 8'h00;
  logic          i_tx_done = 1'b0;
  logic          o_tx_dv;
  logic [7:0]    o_tx_byte;
  logic [AW:0]   o_count;
  logic          o_full;
  logic          o_empty;
  logic          o_busy;
`ifdef UART_TXQ_DROP_CNT_EN
  logic [7:0]    o_drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_wr_dv    (i_wr_dv),
    .i_wr_byte  (i_wr_byte),
    .i_tx_done  (i_tx_done),
    .o_tx_dv    (o_tx_dv),
    .o_tx_byte  (o_tx_byte),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty),
`ifdef UART_TXQ_DROP_CNT_EN
    .o_drop_cnt (o_drop_cnt),
`endif
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference model: the queue holds stored bytes, busy means a frame is in flight.
  logic [7:0] mq[$];
  bit         m_busy = 1'b0;
  bit         m_dv   = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_drop = 0;

  task automatic model_edge(input bit rst, input bit wr, input logic [7:0] b, input bit done);
    bit was_full;
    bit launch;
    if (rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_dv   = 1'b0;
      m_byte = 8'h00;
      m_drop = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      launch   = !m_busy && (mq.size() != 0);
      m_dv     = launch;
      if (launch) begin
        m_byte = mq.pop_front();
        m_busy = 1'b1;
      end else if (m_busy && done) begin
        m_busy = 1'b0;
      end
      if (wr) begin
        if (was_full) begin
          if (m_drop < 255) m_drop++;
        end else begin
          mq.push_back(b);
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit wr, input logic [7:0] b, input bit done);
    i_rst     = rst;
    i_wr_dv   = wr;
    i_wr_byte = b;
    i_tx_done = done;
    @(posedge clk);
    model_edge(rst, wr, b, done);
    #1;
    i_rst     = 1'b0;
    i_wr_dv   = 1'b0;
    i_tx_done = 1'b0;
  endtask

  task automatic check_model();
    check("tx_dv",   32'(o_tx_dv),   32'(m_dv));
    check("tx_byte", 32'(o_tx_byte), 32'(m_byte));
    check("count",   32'(o_count),   32'(mq.size()));
    check("full",    32'(o_full),    32'(mq.size() == DEPTH));
    check("empty",   32'(o_empty),   32'(mq.size() == 0));
    check("busy",    32'(o_busy),    32'(m_busy));
`ifdef UART_TXQ_DROP_CNT_EN
    check("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
`endif
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((mq.size() != 0 || m_busy) && n < budget) begin
      step(1'b0, 1'b0, 8'h00, m_busy);
      check_model();
      n++;
    end
    check("drained empty", 32'(o_empty), 32'd1);
    check("drained busy",  32'(o_busy),  32'd0);
  endtask

  typedef struct {
    bit         rst;
    bit         wr;
    logic [7:0] b;
    bit         done;
    bit         e_dv;
    logic [7:0] e_byte;
    int         e_cnt;
    bit         e_busy;
    bit         e_empty;
  } vec_t;

  vec_t        tbl[12];
  logic [7:0]  launches[$];
  int          cyc;
  int          launch_cyc;
  int          last_done;
  bit          dn;
  bit          rs;
  bit          wr;
  int          wr_pct;

  initial begin
    // rst wr byte done | dv byte cnt busy empty
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 8'hBE, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hBE, 0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hBE, 0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hBE, 0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hBE, 0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'hBE, 1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h6B, 1'b0, 1'b1, 8'h5A, 1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h6B, 0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].b, tbl[i].done);
      check($sformatf("vec%0d dv", i),    32'(o_tx_dv),   32'(tbl[i].e_dv));
      check($sformatf("vec%0d byte", i),  32'(o_tx_byte), 32'(tbl[i].e_byte));
      check($sformatf("vec%0d count", i), 32'(o_count),   32'(tbl[i].e_cnt));
      check($sformatf("vec%0d busy", i),  32'(o_busy),    32'(tbl[i].e_busy));
      check($sformatf("vec%0d empty", i), 32'(o_empty),   32'(tbl[i].e_empty));
    end
    check("reset full", 32'(o_full), 32'd0);

    // Burst 01..05, done pulsed 20 cycles after each launch.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    launches.delete();
    cyc        = 0;
    launch_cyc = -1000;
    last_done  = -1000;
    while (!(launches.size() == 5 && !m_busy) && cyc < 400) begin
      dn = m_busy && (cyc == launch_cyc + 20);
      if (dn) last_done = cyc;
      step(1'b0, cyc < 5, 8'(cyc + 1), dn);
      check_model();
      if (o_tx_dv) begin
        if (launches.size() > 0) check("burst launch gap", 32'(cyc - last_done), 32'd1);
        launches.push_back(o_tx_byte);
        launch_cyc = cyc;
      end
      cyc++;
    end
    check("burst timeout", 32'(cyc < 400), 32'd1);
    check("burst launches", 32'(launches.size()), 32'd5);
    for (int i = 0; i < launches.size(); i++) begin
      check($sformatf("burst byte%0d", i), 32'(launches[i]), 32'(i + 1));
    end
    check("burst end empty", 32'(o_empty), 32'd1);

    // Fill with the transmitter stalled on a prior frame.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hA0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("stall busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
      check_model();
      if (i == 14) check("full before 16th", 32'(o_full), 32'd0);
      if (i == 15) check("full after 16th", 32'(o_full), 32'd1);
    end
    check("count after 17", 32'(o_count), 32'd16);
    check("full after 17", 32'(o_full), 32'd1);
`ifdef UART_TXQ_DROP_CNT_EN
    check("drop count", 32'(o_drop_cnt), 32'd1);
`endif
    drain(200);

    // 15 entries queued, then simultaneous write and pop.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hA1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
      check_model();
    end
    check("fifteen count", 32'(o_count), 32'd15);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("after done count", 32'(o_count), 32'd15);
    step(1'b0, 1'b1, 8'h77, 1'b0);
    check("wr+pop count", 32'(o_count), 32'd15);
    check("wr+pop dv", 32'(o_tx_dv), 32'd1);
    check("wr+pop byte", 32'(o_tx_byte), 32'h30);
    drain(200);

    // Reset while a frame is in flight with 3 bytes queued.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hC1, 1'b0);
    step(1'b0, 1'b1, 8'hC2, 1'b0);
    step(1'b0, 1'b1, 8'hC3, 1'b0);
    step(1'b0, 1'b1, 8'hC4, 1'b0);
    check("pre-reset count", 32'(o_count), 32'd3);
    check("pre-reset busy", 32'(o_busy), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("mid reset count", 32'(o_count), 32'd0);
    check("mid reset busy", 32'(o_busy), 32'd0);
    check("mid reset empty", 32'(o_empty), 32'd1);
    check("mid reset byte", 32'(o_tx_byte), 32'h00);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check($sformatf("stray done no launch %0d", i), 32'(o_tx_dv), 32'd0);
    end
    check_model();

    // Randomized traffic against the model.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      wr_pct = ((c / 500) % 2 == 0) ? 90 : 30;
      rs = ($urandom_range(0, 299) == 0);
      wr = ($urandom_range(0, 99) < wr_pct);
      dn = m_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 9) == 0);
      step(rs, wr, 8'($urandom_range(0, 255)), dn);
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 2..256).
REQ-002 The block SHALL have parameter AW, default $clog2(DEPTH), meaning pointer width.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port i_wr_dv  input  1  one-cycle write strobe from the byte producer.
REQ-006 The block SHALL have port i_wr_byte  input  8  byte to enqueue, sampled when i_wr_dv=1.
REQ-007 The block SHALL have port i_tx_done  input  1  one-cycle pulse from the UART transmitter at the end of its stop bit.
REQ-008 The block SHALL have port o_tx_dv  output  1  one-cycle launch strobe to the transmitter's i_tx_dv.
REQ-009 The block SHALL have port o_tx_byte  output  8  byte to the transmitter's i_tx_byte, valid while o_tx_dv=1.
REQ-010 The block SHALL have port o_count  output  AW+1  current number of stored bytes.
REQ-011 The block SHALL have ports o_full and o_empty  output  1 each  registered FIFO status flags.
REQ-012 The block SHALL have port o_busy  output  1  high while a launched byte is still being transmitted.

Function
REQ-013 The FIFO SHALL be a circular buffer with AW-bit read and write pointers that wrap from DEPTH-1 to 0, plus an (AW+1)-bit occupancy count.
REQ-014 A write with o_full=0 SHALL store i_wr_byte at the write pointer and increment the pointer and count on the same edge.
REQ-015 A write with o_full=1 SHALL be dropped, even if a pop occurs in the same cycle, and SHALL leave the FIFO contents unchanged.
REQ-016 The FSM SHALL have exactly two states: IDLE and WAIT_DONE.
REQ-017 In IDLE with o_empty=0, the block SHALL assert o_tx_dv for one cycle with o_tx_byte equal to the head byte, pop the head on that edge, and enter WAIT_DONE.
REQ-018 o_tx_dv and o_tx_byte SHALL be registered; a byte written into an empty idle queue at edge N SHALL appear on o_tx_dv after edge N+1.
REQ-019 In WAIT_DONE, i_tx_done=1 SHALL return the FSM to IDLE; the next launch SHALL occur no earlier than the cycle after return.
REQ-020 i_tx_done SHALL be ignored while the FSM is in IDLE.
REQ-021 A simultaneous write and pop with the FIFO neither full nor empty SHALL leave o_count unchanged and advance both pointers.
REQ-022 o_busy SHALL equal (state==WAIT_DONE); o_tx_byte SHALL hold its last value when o_tx_dv=0.

Reset
REQ-023 With i_rst=1 at a rising edge, the block SHALL clear both pointers, set o_count=0, o_empty=1, o_full=0, o_tx_dv=0, o_tx_byte=8'h00, o_busy=0, and state=IDLE.
REQ-024 Reset mid-transmission SHALL discard all queued bytes and SHALL NOT abort the downstream frame; any i_tx_done that arrives after reset SHALL be ignored.
REQ-025 RAM contents SHALL NOT require reset.

Configuration
REQ-026 When the macro UART_TXQ_DROP_CNT_EN is defined, the block SHALL add output o_drop_cnt (8 bits, reset 0), which increments on every dropped write and saturates at 8'hFF.
REQ-027 When UART_TXQ_DROP_CNT_EN is undefined, the port and its counter SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-028 A shared package uart_pkg SHALL hold the FSM state typedef (TXQ_IDLE, TXQ_WAIT_DONE) and the constant UART_BYTE_W=8.
REQ-029 The storage SHALL be one sub-module, uart_sync_fifo (parameters DEPTH and AW), instantiated once; the FSM and launch logic SHALL live in uart_tx_queue.

Verification
REQ-030 Reset, then write 8'hBE into an idle queue -> o_tx_dv pulses once after the next edge with o_tx_byte=8'hBE; o_busy=1 until i_tx_done is pulsed.
REQ-031 Burst-write 8'h01..8'h05 on consecutive cycles, with i_tx_done pulsed 20 cycles after each launch -> five launches in order 01..05, each one cycle after the preceding i_tx_done, and o_empty=1 at the end.
REQ-032 Write 17 bytes with the transmitter stalled -> o_full=1 after the 16th byte; the 17th is dropped, o_count=16, and o_drop_cnt=1 when the macro is defined.
REQ-033 With 15 entries queued, write and pop in the same cycle -> o_count stays 15 and the pointers wrap correctly past index 15 to 0.
REQ-034 Assert i_rst while in WAIT_DONE with 3 bytes queued -> o_count=0, o_busy=0, and no launch occurs on a following stray i_tx_done.
REQ-035 Pulse i_tx_done while in IDLE with an empty queue -> no state change and o_tx_dv stays 0.
